// File: rtl/qdec_pkg.sv
// Shared types and constants for the quadrature-decoder scan sequencer.
package qdec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HOMING,
        ARMED,
        RUN,
        DONE,
        ERROR
    } qdec_seq_state_t;

    localparam logic [31:0] TIMEOUT_DISABLED = 32'd0;

    function automatic logic is_busy(input qdec_seq_state_t s);
        return (s == HOMING) || (s == ARMED) || (s == RUN);
    endfunction

endpackage

// File: rtl/qdec_watchdog.sv
// Inactivity watchdog: counts enabled clocks since the last clear and flags
// once the count reaches a non-zero limit.
module qdec_watchdog
    import qdec_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_aresetn,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic [31:0] limit_i,
    output logic        expired_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        // NOTE: every path assigns cnt_d, so this block stays purely combinational (no latch).
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!i_aresetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear in the same cycle (step seen or fresh state) rescues the scan.
    assign expired_o = enable_i && !clear_i && (limit_i != TIMEOUT_DISABLED) && (cnt_q >= limit_i);

endmodule

// File: rtl/qdec_scan_sequencer.sv
// Scan sequencer: enables the decoder, waits for homing and the start position,
// then forwards a fixed number of same-direction triggers and reports done/timeout.
module qdec_scan_sequencer
    import qdec_pkg::*;
#(
    parameter int POSITION_SIZE = 32,
    parameter int CNT_W         = 16
) (
    input  logic                     i_clk,
    input  logic                     i_aresetn,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     cfg_dir,
    input  logic [POSITION_SIZE-1:0] cfg_start_pos,
    input  logic [CNT_W-1:0]         cfg_nof_trig,
    input  logic [31:0]              cfg_timeout,
    input  logic                     dec_zero_found,
    input  logic                     dec_direction,
    input  logic                     dec_step_toggle,
    input  logic                     dec_trigger,
    input  logic [POSITION_SIZE-1:0] dec_position,
    output logic                     dec_enable,
    output logic                     trig_out,
    output logic [CNT_W-1:0]         trig_cnt,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);

    qdec_seq_state_t state_q, state_d;
    logic             dec_enable_q, dec_enable_d;
    logic             trig_out_q, trig_out_d;
    logic [CNT_W-1:0] trig_cnt_q, trig_cnt_d;
    logic             done_q, busy_q, timeout_err_q;
    logic             step_q, entry_q;

    logic                     cfg_dir_q;
    logic [POSITION_SIZE-1:0] cfg_start_pos_q;
    logic [CNT_W-1:0]         cfg_nof_trig_q;
    logic [31:0]              cfg_timeout_q;

    logic             start_ok, cfg_load, pos_reached, trig_hit;
    logic             wd_clear, wd_enable, wd_expired;
    logic [CNT_W-1:0] cnt_inc;

    assign start_ok    = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
    assign cfg_load    = start_ok && !abort;
    assign pos_reached = cfg_dir_q ? ($signed(dec_position) >= $signed(cfg_start_pos_q))
                                   : ($signed(dec_position) <= $signed(cfg_start_pos_q));
    assign trig_hit    = dec_trigger && (dec_direction == cfg_dir_q);
    assign cnt_inc     = (trig_cnt_q == '1) ? trig_cnt_q : trig_cnt_q + CNT_W'(1);

    // Once homed, the HOMING watchdog stops counting idle clocks.
    assign wd_clear  = (step_q ^ dec_step_toggle) || entry_q;
    assign wd_enable = ((state_q == HOMING) && !dec_zero_found) || (state_q == ARMED) || (state_q == RUN);

    qdec_watchdog u_watchdog (
        .i_clk     (i_clk),
        .i_aresetn (i_aresetn),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .limit_i   (cfg_timeout_q),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        dec_enable_d = dec_enable_q;
        trig_out_d   = 1'b0;
        trig_cnt_d   = trig_cnt_q;
        if (abort) begin
            state_d      = IDLE;
            dec_enable_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_d      = HOMING;
                        dec_enable_d = 1'b1;
                        trig_cnt_d   = '0;
                    end else if (state_q == DONE) begin
                        state_d = IDLE;
                    end
                end
                HOMING: begin
                    if (dec_zero_found) state_d = ARMED;
                    else if (wd_expired) state_d = ERROR;
                end
                ARMED: begin
                    if (pos_reached) state_d = (cfg_nof_trig_q == '0) ? DONE : RUN;
                    else if (wd_expired) state_d = ERROR;
                end
                RUN: begin
                    // The last trigger wins over a coincident timeout.
                    if (trig_hit) begin
                        trig_out_d = 1'b1;
                        trig_cnt_d = cnt_inc;
                    end
                    if (trig_hit && (cnt_inc == cfg_nof_trig_q)) state_d = DONE;
                    else if (wd_expired) state_d = ERROR;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q       <= IDLE;
            dec_enable_q  <= 1'b0;
            trig_out_q    <= 1'b0;
            trig_cnt_q    <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            step_q        <= 1'b0;
            entry_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            dec_enable_q  <= dec_enable_d;
            trig_out_q    <= trig_out_d;
            trig_cnt_q    <= trig_cnt_d;
            done_q        <= (state_d == DONE);
            busy_q        <= is_busy(state_d);
            timeout_err_q <= (state_d == ERROR);
            step_q        <= dec_step_toggle;
            entry_q       <= (state_d != state_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            cfg_dir_q       <= 1'b0;
            cfg_start_pos_q <= '0;
            cfg_nof_trig_q  <= '0;
            cfg_timeout_q   <= TIMEOUT_DISABLED;
        end else if (cfg_load) begin
            cfg_dir_q       <= cfg_dir;
            cfg_start_pos_q <= cfg_start_pos;
            cfg_nof_trig_q  <= cfg_nof_trig;
            cfg_timeout_q   <= cfg_timeout;
        end
    end

    assign dec_enable  = dec_enable_q;
    assign trig_out    = trig_out_q;
    assign trig_cnt    = trig_cnt_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_qdec_scan_sequencer.sv
// Scoreboard bench: stimulus pushes expected trigger/done/timeout events,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_qdec_scan_sequencer;

    logic        i_clk = 1'b0;
    logic        i_aresetn = 1'b0;
    logic        start = 1'b0, abort = 1'b0, cfg_dir = 1'b0;
    logic [31:0] cfg_start_pos = '0;
    logic [15:0] cfg_nof_trig = '0;
    logic [31:0] cfg_timeout = '0;
    logic        dec_zero_found = 1'b0, dec_direction = 1'b0, dec_step_toggle = 1'b0, dec_trigger = 1'b0;
    logic [31:0] dec_position = '0;
    logic        dec_enable, trig_out, busy, done, timeout_err;
    logic [15:0] trig_cnt;

    qdec_scan_sequencer #(.POSITION_SIZE(32), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_aresetn(i_aresetn), .start(start), .abort(abort),
        .cfg_dir(cfg_dir), .cfg_start_pos(cfg_start_pos), .cfg_nof_trig(cfg_nof_trig),
        .cfg_timeout(cfg_timeout), .dec_zero_found(dec_zero_found), .dec_direction(dec_direction),
        .dec_step_toggle(dec_step_toggle), .dec_trigger(dec_trigger), .dec_position(dec_position),
        .dec_enable(dec_enable), .trig_out(trig_out), .trig_cnt(trig_cnt), .busy(busy),
        .done(done), .timeout_err(timeout_err)
    );

    always #5 i_clk = ~i_clk;

    typedef enum int {EV_TRIG, EV_DONE, EV_TIMEOUT} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       cnt;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  pos = 0;
    bit  tq[$];
    logic prev_to = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input ev_kind_e k, input int c);
        ev_t e;
        e.kind = k;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    task automatic expect_event(input ev_kind_e k);
        ev_t e;
        check($sformatf("event_expected_%s", k.name()), exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("event_kind", e.kind, k);
            if (k == EV_TIMEOUT) check("timeout_busy", busy, 0);
            else check($sformatf("%s_trig_cnt", k.name()), trig_cnt, e.cnt);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_aresetn) begin
            if (trig_out) expect_event(EV_TRIG);
            if (done) expect_event(EV_DONE);
            if (timeout_err && !prev_to) expect_event(EV_TIMEOUT);
        end
        prev_to <= timeout_err;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_step(input bit d);
        pos             = d ? pos + 1 : pos - 1;
        dec_position    = pos;
        dec_direction   = d;
        dec_step_toggle = ~dec_step_toggle;
        tick();
    endtask

    task automatic send_trig(input bit d);
        dec_direction = d;
        dec_trigger   = 1'b1;
        tick();
        dec_trigger = 1'b0;
    endtask

    function automatic bit reached(input bit d, input int p, input int s);
        return d ? (p >= s) : (p <= s);
    endfunction

    task automatic pulse_start(input bit d, input int s, input int n, input int t);
        cfg_dir = d; cfg_start_pos = s; cfg_nof_trig = 16'(n); cfg_timeout = t;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic scramble_cfg();
        cfg_dir = $urandom; cfg_start_pos = $urandom; cfg_nof_trig = 16'($urandom);
        cfg_timeout = 1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // One complete scan; tq holds the trigger directions issued once running.
    task automatic run_scan(input bit dir, input int spos, input int nof, input bit homed, input bit poke);
        int  fwd = 0;
        int  step_to;
        bit  d;
        dec_zero_found = homed;
        pulse_start(dir, spos, nof, ($urandom_range(0, 1) != 0) ? 0 : 300);
        scramble_cfg();
        check("start_busy", busy, 1);
        check("start_enable", dec_enable, 1);
        check("start_err_clear", timeout_err, 0);
        check("start_cnt_clear", trig_cnt, 0);
        if (!homed) begin
            repeat ($urandom_range(1, 15)) tick();
            dec_zero_found = 1'b1;
        end
        if (nof == 0 && reached(dir, pos, spos)) push_ev(EV_DONE, 0);
        while (!reached(dir, pos, spos)) begin
            step_to = dir ? pos + 1 : pos - 1;
            if (nof == 0 && reached(dir, step_to, spos)) push_ev(EV_DONE, 0);
            do_step(dir);
            repeat ($urandom_range(0, 2)) tick();
            if (!reached(dir, pos, spos) && $urandom_range(0, 2) == 0) send_trig($urandom_range(0, 1) != 0);
        end
        repeat (3) tick();
        foreach (tq[i]) begin
            d = tq[i];
            do_step(d);
            if (d == dir && fwd < nof) begin
                fwd++;
                push_ev(EV_TRIG, fwd);
                if (fwd == nof) push_ev(EV_DONE, fwd);
            end
            send_trig(d);
            if (poke && i == 0 && fwd < nof) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain("scan_drain");
        repeat (2) tick();
        check("end_busy", busy, 0);
        check("end_enable", dec_enable, 1);
        check("end_trig_cnt", trig_cnt, 16'(nof));
        check("end_err", timeout_err, 0);
    endtask

    task automatic fill_tq(input bit dir, input int nof);
        int m = 0;
        tq.delete();
        while (m < nof) begin
            tq.push_back($urandom_range(0, 1) != 0);
            if (tq[tq.size()-1] == dir) m++;
        end
        repeat ($urandom_range(0, 2)) tq.push_back($urandom_range(0, 1) != 0);
    endtask

    task automatic timeout_scan(input int limit);
        int t0;
        dec_zero_found = 1'b0;
        push_ev(EV_TIMEOUT, 0);
        pulse_start(1'b1, pos + 5, 2, limit);
        scramble_cfg();
        t0 = cyc;
        while (!timeout_err && (cyc - t0) < limit + 20) tick();
        check("timeout_seen", timeout_err, 1);
        check("timeout_window", ((cyc - t0) >= limit) && ((cyc - t0) <= limit + 4), 1);
        check("timeout_busy_low", busy, 0);
        check("timeout_enable_kept", dec_enable, 1);
        wait_drain("timeout_drain");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int spos, nof;
        bit dir;
        repeat (3) tick();
        i_aresetn = 1'b1;
        tick();
        check("rst_state_busy", busy, 0);
        check("rst_enable", dec_enable, 0);
        check("rst_trig_out", trig_out, 0);
        check("rst_done", done, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_trig_cnt", trig_cnt, 0);

        // Homed, 0 -> 10 upward, three forwarded triggers.
        pos = 0; dec_position = 0;
        tq = '{1, 1, 1};
        run_scan(1'b1, 10, 3, 1'b1, 1'b0);

        // Reverse-direction triggers dropped.
        tq = '{0, 0, 1, 1};
        run_scan(1'b1, pos + 2, 2, 1'b1, 1'b0);

        // Downward scan to -5 from 0 with a signed compare.
        pos = 0; dec_position = 0;
        tq = '{0, 1, 0};
        run_scan(1'b0, -5, 2, 1'b0, 1'b0);
        check("neg_pos_reached", dec_position, 32'hFFFF_FFFB - 32'h1);

        // Zero triggers: done on reaching the start position; start during RUN ignored.
        tq = '{1, 0};
        run_scan(1'b1, pos + 4, 0, 1'b1, 1'b0);
        tq = '{1, 1, 1, 1};
        run_scan(1'b1, pos + 3, 3, 1'b1, 1'b1);

        // Timeout in HOMING, then restart straight from ERROR.
        timeout_scan(100);
        fill_tq(1'b0, 2);
        run_scan(1'b0, pos - 3, 2, 1'b0, 1'b0);

        // Abort after one of four triggers.
        dec_zero_found = 1'b1;
        pulse_start(1'b1, pos + 2, 4, 0);
        do_step(1'b1);
        do_step(1'b1);
        repeat (3) tick();
        do_step(1'b1);
        push_ev(EV_TRIG, 1);
        send_trig(1'b1);
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_enable", dec_enable, 0);
        check("abort_trig_cnt", trig_cnt, 1);
        check("abort_trig_out", trig_out, 0);
        do_step(1'b1);
        send_trig(1'b1);
        repeat (10) tick();
        check("abort_no_done", exp_q.size(), 0);
        check("abort_enable_held", dec_enable, 0);

        // Abort clears a sticky timeout.
        timeout_scan(20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_err_clear", timeout_err, 0);
        check("abort_err_enable", dec_enable, 0);

        // Randomised scans.
        repeat (20) begin
            dir  = $urandom_range(0, 1) != 0;
            nof  = $urandom_range(0, 5);
            spos = dir ? pos + int'($urandom_range(0, 18)) - 3 : pos - int'($urandom_range(0, 18)) + 3;
            fill_tq(dir, nof);
            run_scan(dir, spos, nof, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
